// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: breathing-profile duty source for the pwm block.
// Ramps duty from a latched minimum to a latched maximum, holds, ramps back
// down, holds, then finishes or loops. Time advances only on step pulses.
module pwm_ramp_sequencer #(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] min_duty,
  input  logic [N-1:0] max_duty,
  input  logic [M-1:0] dwell,
  input  logic [M-1:0] hold_hi,
  input  logic [M-1:0] hold_lo,
  input  logic         loop,
  output logic [N-1:0] duty,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] duty_d;
  logic [M-1:0] cnt_q;
  logic [M-1:0] cnt_d;
  logic [M-1:0] cnt_inc;
  logic         busy_d;
  logic         done_d;
  logic         load_cfg;

  logic [N-1:0] min_l;
  logic [N-1:0] max_l;
  logic [M-1:0] dwell_l;
  logic [M-1:0] hold_hi_l;
  logic [M-1:0] hold_lo_l;
  logic         loop_l;
  logic [M-1:0] dwell_eff;

  assign cnt_inc   = cnt_q + 1'b1;
  // A zero dwell would never complete, so it behaves as one step per level.
  assign dwell_eff = (dwell_l == '0) ? {{(M-1){1'b0}}, 1'b1} : dwell_l;

  // Profile configuration captured at start; deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      min_l     <= min_duty;
      max_l     <= max_duty;
      dwell_l   <= dwell;
      hold_hi_l <= hold_hi;
      hold_lo_l <= hold_lo;
      loop_l    <= loop;
    end
  end

  // State, duty, step counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      duty    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      duty    <= duty_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, duty and counter logic; stop overrides the ena freeze.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_cfg = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      duty_d  = '0;
      cnt_d   = '0;
    end else if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            load_cfg = 1'b1;
            duty_d   = min_duty;
            cnt_d    = '0;
            state_d  = S_UP;
          end
        end
        S_UP: begin
          if (duty >= max_l) begin
            state_d = S_HOLD_HI;
            cnt_d   = '0;
          end else if (step) begin
            if (cnt_inc == dwell_eff) begin
              duty_d = duty + 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HOLD_HI: begin
          if ((hold_hi_l == '0) || (step && (cnt_inc == hold_hi_l))) begin
            state_d = S_DOWN;
            cnt_d   = '0;
          end else if (step) begin
            cnt_d = cnt_inc;
          end
        end
        S_DOWN: begin
          if (duty <= min_l) begin
            state_d = S_HOLD_LO;
            cnt_d   = '0;
          end else if (step) begin
            if (cnt_inc == dwell_eff) begin
              duty_d = duty - 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HOLD_LO: begin
          if ((hold_lo_l == '0) || (step && (cnt_inc == hold_lo_l))) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = loop_l ? S_UP : S_IDLE;
          end else if (step) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // busy is registered from the upcoming state so it tracks state exactly.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed scenarios with literal
// expectations plus randomized stimulus, all checked every cycle against a
// behavioural phase/remaining-steps model.
module tb_pwm_ramp_sequencer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       step;
  logic       start;
  logic       stop;
  logic [3:0] min_duty;
  logic [3:0] max_duty;
  logic [7:0] dwell;
  logic [7:0] hold_hi;
  logic [7:0] hold_lo;
  logic       loop;
  logic [3:0] duty;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  pwm_ramp_sequencer #(.N(4), .M(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .start(start), .stop(stop),
    .min_duty(min_duty), .max_duty(max_duty), .dwell(dwell),
    .hold_hi(hold_hi), .hold_lo(hold_lo), .loop(loop),
    .duty(duty), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: profile phase plus steps remaining in the current phase.
  localparam int P_IDLE = 0, P_UP = 1, P_HH = 2, P_DOWN = 3, P_HL = 4;
  int m_ph, m_duty, m_rem, m_done;
  int l_min, l_max, l_dw, l_hh, l_hl, l_loop;
  bit mv = 1'b0;

  always @(posedge clk) begin : model
    int ph, du, rem, dn, lmin, lmax, ldw, lhh, lhl, llp;
    ph = m_ph; du = m_duty; rem = m_rem; dn = 0;
    lmin = l_min; lmax = l_max; ldw = l_dw; lhh = l_hh; lhl = l_hl; llp = l_loop;
    if (rst || stop) begin
      ph = P_IDLE; du = 0; rem = 0;
    end else if (ena) begin
      case (ph)
        P_IDLE: if (start) begin
          lmin = int'(min_duty); lmax = int'(max_duty);
          ldw = (dwell == 0) ? 1 : int'(dwell);
          lhh = int'(hold_hi); lhl = int'(hold_lo); llp = int'(loop);
          du = lmin; ph = P_UP; rem = ldw;
        end
        P_UP: if (du >= lmax) begin
          ph = P_HH; rem = lhh;
        end else if (step) begin
          rem = rem - 1;
          if (rem == 0) begin du = du + 1; rem = ldw; end
        end
        P_HH: begin
          if (rem != 0 && step) rem = rem - 1;
          else if (rem != 0) rem = rem + 0;
          if (rem == 0) begin ph = P_DOWN; rem = ldw; end
        end
        P_DOWN: if (du <= lmin) begin
          ph = P_HL; rem = lhl;
        end else if (step) begin
          rem = rem - 1;
          if (rem == 0) begin du = du - 1; rem = ldw; end
        end
        P_HL: begin
          if (rem != 0 && step) rem = rem - 1;
          if (rem == 0) begin dn = 1; ph = llp ? P_UP : P_IDLE; rem = ldw; end
        end
        default: ph = P_IDLE;
      endcase
    end
    if (rst) mv <= 1'b1;
    m_ph <= ph; m_duty <= du; m_rem <= rem; m_done <= dn;
    l_min <= lmin; l_max <= lmax; l_dw <= ldw; l_hh <= lhh; l_hl <= lhl; l_loop <= llp;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare DUT outputs with the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mv) begin
      chk("model_duty", int'(duty), m_duty);
      chk("model_busy", int'(busy), (m_ph != P_IDLE) ? 1 : 0);
      chk("model_done", int'(done), m_done);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; ena = 1'b1; step = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic config_set(input int mn, input int mx, input int dw,
                            input int hh, input int hl, input int lp);
    min_duty = 4'(mn); max_duty = 4'(mx); dwell = 8'(dw);
    hold_hi = 8'(hh); hold_lo = 8'(hl); loop = lp[0];
  endtask

  initial begin : stim
    int exp_duty [13] = '{2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 2, 2, 2};
    int ch [3];
    int nch, prev, dones, peak, done_idx;
    rst = 1'b1; ena = 1'b1; step = 1'b0; start = 1'b1; stop = 1'b0;
    config_set(3, 9, 1, 1, 1, 0);

    // Reset dominates start and step.
    for (int i = 0; i < 2; i++) begin
      step = i[0];
      tick();
      chk("reset_duty", int'(duty), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      chk("idle_busy", int'(busy), 0);
    end

    // Basic pass with literal trace.
    do_reset();
    config_set(2, 5, 1, 2, 1, 0);
    step = 1'b1; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      start = 1'b0;
      chk("basic_duty", int'(duty), exp_duty[i]);
      chk("basic_busy", int'(busy), (i < 11) ? 1 : 0);
      chk("basic_done", int'(done), (i == 11) ? 1 : 0);
      dones += int'(done);
    end
    chk("basic_done_count", dones, 1);

    // Dwell scaling: dwell=3 then dwell=0, step every 4th cycle.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      config_set(0, 3, (pass == 0) ? 3 : 0, 0, 0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      nch = 0; prev = int'(duty);
      for (int c = 0; c < 60; c++) begin
        step = (c % 4 == 0);
        tick();
        if (int'(duty) > prev && nch < 3) begin ch[nch] = c; nch++; end
        prev = int'(duty);
      end
      chk("dwell_changes", nch, 3);
      if (nch == 3) begin
        chk("dwell_first", ch[0], (pass == 0) ? 8 : 0);
        chk("dwell_gap1", ch[1] - ch[0], (pass == 0) ? 12 : 4);
        chk("dwell_gap2", ch[2] - ch[1], (pass == 0) ? 12 : 4);
      end
    end

    // Freeze mid-dwell at duty=3 and resume the remaining count.
    do_reset();
    config_set(0, 7, 4, 0, 0, 0);
    step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && duty != 4'd3; i++) tick();
    chk("freeze_reach3", int'(duty), 3);
    tick(); tick();
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("freeze_duty", int'(duty), 3);
      chk("freeze_busy", int'(busy), 1);
    end
    ena = 1'b1;
    tick();
    chk("resume_duty_a", int'(duty), 3);
    tick();
    chk("resume_duty_b", int'(duty), 4);

    // Loop with a live max change, then stop.
    do_reset();
    config_set(1, 4, 1, 1, 1, 1);
    step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; max_duty = 4'd7;
    dones = 0; peak = 0;
    for (int i = 0; i < 200 && dones < 2; i++) begin
      tick();
      if (int'(duty) > peak) peak = int'(duty);
      dones += int'(done);
    end
    chk("loop_dones", dones, 2);
    chk("loop_peak", peak, 4);
    chk("loop_busy", int'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_duty", int'(duty), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);

    // Degenerate bounds: min above max.
    do_reset();
    config_set(7, 3, 1, 1, 1, 0);
    step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("degen_start", int'(duty), 7);
    done_idx = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("degen_duty", int'(duty), 7);
      if (done && done_idx < 0) done_idx = i;
    end
    chk("degen_done_idx", done_idx, 4);

    // Randomized operation against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      ena   = ($urandom_range(0, 9) != 0);
      step  = $urandom_range(0, 1) == 1;
      start = ($urandom_range(0, 7) == 0);
      config_set($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Upstream duty-cycle source for the `pwm` block. It generates a programmable "breathing" profile: ramp `duty` up from a minimum to a maximum, hold, ramp down, hold, then finish or loop. Time advances only on `step` pulses from a `pulse_generator` instance, so profile speed is set by that generator's `ticks`. The `duty` output connects directly to `pwm.duty`.

Parameters:
- N, default 4: duty width; must equal the downstream `pwm` N.
- M, default 8: width of the dwell and hold step counts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  enable; when low, the sequencer freezes
- step  in  1  single-cycle time-base pulse from `pulse_generator`
- start  in  1  begin a sequence; sampled only in IDLE
- stop  in  1  abort the sequence and return to IDLE
- min_duty  in  N  lower duty bound
- max_duty  in  N  upper duty bound
- dwell  in  M  step pulses per duty level while ramping
- hold_hi  in  M  step pulses to hold at the maximum
- hold_lo  in  M  step pulses to hold at the minimum
- loop  in  1  repeat the profile indefinitely
- duty  out  N  registered duty value to `pwm`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of each profile pass

Behaviour:
- **Reset:** one clock with `rst=1` forces state=IDLE, duty=0, busy=0, done=0, step counter=0. Latched configuration is don't-care.
- **Priority (highest first):** rst, stop, ena=0 freeze, normal operation.
- **stop=1**, any state, any `ena`: next edge gives IDLE, duty=0, busy=0, counter=0. `done` is not pulsed.
- **ena=0:** state, duty, counter and latches hold; `step` and `start` are ignored; done=0.
- **Counting:** the counter advances only on cycles with `step=1` and `ena=1`.
  - Effective count = programmed value, except dwell=0 is treated as 1.
  - hold_x=0 means leave the hold state on the first cycle in it, without waiting for a step.
  - Counter clears on every state change.
- **States and transitions:**
  - **IDLE:**
    - `start=1` latches min_l, max_l, dwell_l, hold_hi_l, hold_lo_l, loop_l; duty<=min_duty; busy<=1; go to UP.
    - Otherwise duty holds its current value.
    - `start` while busy is ignored.
  - **UP:**
    - If duty>=max_l, go to HOLD_HI; this takes one cycle and needs no step.
    - Otherwise, on the step that completes dwell_l counts: duty<=duty+1, counter<=0.
  - **HOLD_HI:** after hold_hi_l counted steps, go to DOWN. Duty is unchanged.
  - **DOWN:**
    - If duty<=min_l, go to HOLD_LO; this takes one cycle.
    - Otherwise, on dwell completion: duty<=duty-1.
  - **HOLD_LO:** after hold_lo_l counted steps, done<=1 for one cycle.
    - If loop_l=1, go to UP. Latches are kept; live inputs are not resampled.
    - If loop_l=0, go to IDLE and set busy<=0 on the same edge as done.
- **Arithmetic:** duty increments only when duty<max_l and decrements only when duty>min_l. Duty never wraps and always stays within [min(min_l,max_l), 2^N-1].
- **min_l>=max_l:** duty stays at min_l for the whole profile. UP and DOWN each take one cycle. Both holds still run, and done still pulses.
- **Latency:** every output is registered and updates on the edge after its cause. No combinational path from inputs to outputs.
- **Input changes while busy:** changes to min/max/dwell/hold/loop have no effect until the next start.

Test Plan (N=4, M=8):
- **Reset:** rst=1 for 2 cycles, with start=1 and step toggling.
  - Required: duty=0, busy=0, done=0.
  - After release with start=0: stays in IDLE.
- **Basic pass:** min=2, max=5, dwell=1, hold_hi=2, hold_lo=1, loop=0, step every cycle, start pulsed once.
  - Required: duty sequence 2,3,4,5; 5 held through 2 counted steps; then 4,3,2; 2 held 1 step.
  - Required: exactly one done pulse; busy falls on the same edge; duty stays 2 afterwards.
- **Dwell scaling:** dwell=3, step every 4th cycle, min=0, max=3.
  - Required: duty changes exactly every 12 cycles on the ramp-up.
  - Repeat with dwell=0: duty changes every 4 cycles.
- **Freeze:** during the ramp-up at duty=3, hold ena=0 for 50 cycles with steps present.
  - Required: duty=3 and the state are unchanged during the freeze.
  - Required: after re-enable, the remaining dwell count continues from where it stopped.
- **Loop and stop:**
  - loop=1; change max_duty mid-pass. Required: the second pass still peaks at the originally latched max; done pulses once per pass.
  - Then assert stop for 1 cycle. Required: next cycle duty=0, busy=0, no done.
- **Degenerate bounds:** min=7, max=3, hold_hi=1, hold_lo=1.
  - Required: duty=7 for the whole pass; done pulses after 2 counted steps plus 2 transition cycles; duty never exceeds 7.
